// File: rtl/score_keeper_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : score_keeper_pkg
//  Description : Shared definitions for the score_keeper block: FSM state
//                encodings, BCD digit width and the saturated score value.
//  Revision    : 1.0  initial release
// ============================================================================
package score_keeper_pkg;

    // Width of one packed-BCD digit.
    localparam int BCD_W = 4;

    // Largest legal value of a single BCD digit.
    localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;

    // Digit-serial incrementer FSM encodings.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_INC  = 1'b1;

    // Saturated score for the default five-digit display.
    localparam logic [19:0] SCORE_MAX_BCD = 20'h99999;

endpackage : score_keeper_pkg
`default_nettype wire

// File: rtl/score_keeper_bcd_digit_inc.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_inc
//  Description : Combinational single-digit BCD incrementer.
//                i_digit : current BCD digit
//                o_digit : i_digit + 1, wrapping 9 -> 0
//                o_carry : high when the digit wrapped
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_digit_inc
    import score_keeper_pkg::*;
(
    input  logic [BCD_W-1:0] i_digit,
    output logic [BCD_W-1:0] o_digit,
    output logic             o_carry
);

    // Codes above 9 never occur, but treating them as a carry keeps a
    // corrupted digit from walking through the invalid range.
    assign o_carry = (i_digit >= BCD_NINE);
    assign o_digit = o_carry ? '0 : i_digit + BCD_W'(1);

endmodule : bcd_digit_inc
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : score_keeper
//  Description : Scoring stage between the lane pattern instances and the
//                7-segment driver. Converts per-lane hit/miss rising edges
//                into a saturating packed-BCD score, a combo counter and a
//                score multiplier. Points are credited one at a time by a
//                digit-serial BCD incrementer.
//  Ports       : CLOCK_25    - system clock
//                reset       - asynchronous active-high reset
//                ponto       - per-lane hit levels (rising edge = one hit)
//                erro        - per-lane miss levels (rising edge = one miss)
//                fim_de_jogo - game over, new events ignored while high
//                display     - packed BCD score, digit 0 in bits [3:0]
//                combo       - consecutive hit count, saturates at 255
//                multiplier  - current multiplier, 1..MAX_MULT
//                busy        - points pending or incrementer active
//  Revision    : 1.0  initial release
// ============================================================================
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int LANES      = 8,
    parameter int DIGITS     = 5,
    parameter int MAX_MULT   = 4,
    parameter int COMBO_STEP = 10
)(
    input  logic                      CLOCK_25,
    input  logic                      reset,
    input  logic [LANES-1:0]          ponto,
    input  logic [LANES-1:0]          erro,
    input  logic                      fim_de_jogo,
    output logic [BCD_W*DIGITS-1:0]   display,
    output logic [7:0]                combo,
    output logic [2:0]                multiplier,
    output logic                      busy
);

    localparam int CNT_W = $clog2(LANES + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SUM_W = 16;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(DIGITS - 1);
    localparam logic [7:0]       c_sat      = 8'hFF;

    function automatic logic [CNT_W-1:0] popcount(input logic [LANES-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [LANES-1:0]                r_ponto_q;
    logic [LANES-1:0]                r_erro_q;
    logic [7:0]                      r_pend;
    logic [7:0]                      r_combo;
    logic [0:0]                      r_state;
    logic [IDX_W-1:0]                r_idx;
    logic [DIGITS-1:0][BCD_W-1:0]    r_digits;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic [LANES-1:0]   w_hit_v;
    logic [LANES-1:0]   w_miss_v;
    logic [CNT_W-1:0]   w_nh;
    logic [CNT_W-1:0]   w_nm;
    logic [7:0]         w_quot;
    logic [2:0]         w_mult;
    logic [BCD_W-1:0]   w_cur;
    logic [BCD_W-1:0]   w_next;
    logic               w_carry;
    logic [DIGITS-1:0]  w_nines;
    logic               w_all_nines;
    logic               w_saturate;
    logic               w_dec;
    logic [SUM_W-1:0]   w_pend_sum;
    logic [7:0]         w_pend_nxt;
    logic [8:0]         w_combo_sum;
    logic [7:0]         w_combo_nxt;

    // Edge registers keep tracking during game over so that a level raised
    // while fim_de_jogo is high never produces a late edge.
    assign w_hit_v  = ponto & ~r_ponto_q;
    assign w_miss_v = erro  & ~r_erro_q;
    assign w_nh     = fim_de_jogo ? '0 : popcount(w_hit_v);
    assign w_nm     = fim_de_jogo ? '0 : popcount(w_miss_v);

    assign w_quot = 8'(32'(r_combo) / COMBO_STEP);
    assign w_mult = (w_quot >= 8'(MAX_MULT - 1)) ? 3'(MAX_MULT)
                                                  : 3'(w_quot) + 3'd1;

    // Select the digit currently being incremented.
    always_comb begin
        w_cur = r_digits[0];
        for (int i = 1; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_cur = r_digits[i];
            end
        end
    end

    bcd_digit_inc u_digit_inc (
        .i_digit (w_cur),
        .o_digit (w_next),
        .o_carry (w_carry)
    );

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_nines
            assign w_nines[g] = (r_digits[g] == BCD_NINE);
        end
    endgenerate

    assign w_all_nines = &w_nines;

    // A full score drops all pending points instead of wrapping.
    assign w_saturate = (r_state == ST_IDLE) && (r_pend != 8'd0) && w_all_nines;

    // One point is retired when the incrementer finishes without a carry.
    assign w_dec = (r_state == ST_INC) && !w_carry;

    // Additions and the retired point are netted into a single update.
    assign w_pend_sum = SUM_W'(r_pend) + SUM_W'(w_nh) * SUM_W'(w_mult)
                      - SUM_W'(w_dec);

    always_comb begin
        w_pend_nxt = w_pend_sum[7:0];
        if (w_saturate) begin
            w_pend_nxt = 8'd0;
        end else if (w_pend_sum > SUM_W'(c_sat)) begin
            w_pend_nxt = c_sat;
        end
    end

    // A miss wins over hits in the same cycle; those hits were already
    // scored at the old multiplier through w_pend_sum.
    assign w_combo_sum = 9'(r_combo) + 9'(w_nh);

    always_comb begin
        w_combo_nxt = w_combo_sum[7:0];
        if (w_nm != '0) begin
            w_combo_nxt = 8'd0;
        end else if (w_combo_sum[8]) begin
            w_combo_nxt = c_sat;
        end
    end

    // ------------------------------------------------------------------
    // Event tracking, pending points and combo
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_25 or posedge reset) begin
        if (reset) begin
            r_ponto_q <= '0;
            r_erro_q  <= '0;
            r_pend    <= 8'd0;
            r_combo   <= 8'd0;
        end else begin
            r_ponto_q <= ponto;
            r_erro_q  <= erro;
            r_pend    <= w_pend_nxt;
            r_combo   <= w_combo_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Digit-serial incrementer
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_25 or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_digits <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if ((r_pend != 8'd0) && !w_all_nines) begin
                        r_idx   <= '0;
                        r_state <= ST_INC;
                    end
                end
                ST_INC: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (r_idx == IDX_W'(i)) begin
                            r_digits[i] <= w_next;
                        end
                    end
                    if (!w_carry) begin
                        r_state <= ST_IDLE;
                    end else if (r_idx == c_last_idx) begin
                        // Not reachable: an all-nines score never enters INC.
                        r_state <= ST_IDLE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign display    = r_digits;
    assign combo      = r_combo;
    assign multiplier = w_mult;
    assign busy       = (r_pend != 8'd0) || (r_state != ST_IDLE);

endmodule : score_keeper
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_score_keeper
//  Description : Self-checking bench for score_keeper. A reference model
//                pushes every expected display value (including the
//                intermediate values of a carry chain) into a scoreboard
//                queue as events are driven; a monitor pops and compares
//                each time the display changes. Four digits are used so the
//                saturation case can be reached by real hits in a short run.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_score_keeper;

    localparam int LANES      = 8;
    localparam int D          = 4;
    localparam int MAX_MULT   = 4;
    localparam int COMBO_STEP = 10;
    localparam int DW         = 4 * D;
    localparam int MAXSCORE   = 9999;

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic          fim    = 1'b0;
    logic [7:0]    ponto  = '0;
    logic [7:0]    erro   = '0;
    logic [DW-1:0] display;
    logic [7:0]    combo;
    logic [2:0]    multiplier;
    logic          busy;

    always #20 clk = ~clk;

    score_keeper #(
        .LANES      (LANES),
        .DIGITS     (D),
        .MAX_MULT   (MAX_MULT),
        .COMBO_STEP (COMBO_STEP)
    ) u_dut (
        .CLOCK_25    (clk),
        .reset       (reset),
        .ponto       (ponto),
        .erro        (erro),
        .fim_de_jogo (fim),
        .display     (display),
        .combo       (combo),
        .multiplier  (multiplier),
        .busy        (busy)
    );

    int            n_tests  = 0;
    int            n_fail   = 0;
    logic [DW-1:0] sb_q[$];
    int            m_score  = 0;
    int            m_combo  = 0;
    bit            in_reset = 1'b1;
    logic [DW-1:0] mon_prev = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] to_bcd(input int v);
        logic [DW-1:0] r;
        int x;
        x = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int model_mult();
        int q;
        q = m_combo / COMBO_STEP;
        if (q > MAX_MULT - 1) q = MAX_MULT - 1;
        return 1 + q;
    endfunction

    // One point: each trailing 9 is cleared in its own step before the
    // final digit increments.
    task automatic push_point();
        int v;
        int p;
        if (m_score >= MAXSCORE) return;
        v = m_score;
        p = 10;
        while (((v / (p / 10)) % 10) == 9) begin
            sb_q.push_back(to_bcd((v / p) * p));
            p = p * 10;
        end
        sb_q.push_back(to_bcd(v + 1));
        m_score++;
    endtask

    // Every set bit in the masks is a fresh rising edge.
    task automatic model_event(input logic [7:0] h, input logic [7:0] m);
        int nh;
        int pts;
        if (fim) return;
        nh  = $countones(h);
        pts = nh * model_mult();
        for (int i = 0; i < pts; i++) push_point();
        if (m != 8'd0) m_combo = 0;
        else m_combo = (m_combo + nh > 255) ? 255 : m_combo + nh;
    endtask

    task automatic drive_event(input logic [7:0] h, input logic [7:0] m);
        @(negedge clk);
        ponto = h;
        erro  = m;
        model_event(h, m);
        @(negedge clk);
        ponto = '0;
        erro  = '0;
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        while (busy && c < 2000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 2000) check({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_reset = 1'b1;
        sb_q.delete();
        reset    = 1'b1;
        m_score  = 0;
        m_combo  = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        in_reset = 1'b0;
    endtask

    task automatic preload(input int target);
        int rem;
        while (m_score < target) begin
            rem = target - m_score;
            if (rem >= 8 * model_mult()) drive_event(8'hFF, 8'h00);
            else if (model_mult() > 1)   drive_event(8'h00, 8'h01);
            else                         drive_event(8'h01, 8'h00);
            wait_idle("preload");
        end
    endtask

    // Scoreboard monitor: every display change must match the next entry.
    always @(negedge clk) begin
        if (reset || in_reset) begin
            mon_prev <= display;
        end else if (display !== mon_prev) begin
            if (sb_q.size() == 0) check("sb_unexpected", 32'(display), 32'(mon_prev));
            else                  check("sb_display", 32'(display), 32'(sb_q.pop_front()));
            mon_prev <= display;
        end
    end

    initial begin
        #(40 * 90000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        in_reset = 1'b0;

        check("rst_display", 32'(display), 32'h0);
        check("rst_combo",   32'(combo), 32'd0);
        check("rst_mult",    32'(multiplier), 32'd1);
        check("rst_busy",    32'(busy), 32'd0);

        // Single pulse: display updates two edges after sampling.
        @(negedge clk);
        ponto = 8'h01;
        model_event(8'h01, 8'h00);
        @(negedge clk);
        ponto = '0;
        check("t1_busy",   32'(busy), 32'd1);
        check("t1_combo",  32'(combo), 32'd1);
        @(negedge clk);
        check("t1_disp_k1", 32'(display), 32'h0);
        @(negedge clk);
        check("t1_disp_k2", 32'(display), 32'h1);
        check("t1_idle",    32'(busy), 32'd0);

        // Carry from 9 to 10 costs one extra cycle.
        repeat (8) begin
            drive_event(8'h01, 8'h00);
            wait_idle("t2_fill");
        end
        check("t2_disp9", 32'(display), 32'h9);
        @(negedge clk);
        ponto = 8'h01;
        model_event(8'h01, 8'h00);
        @(negedge clk);
        ponto = '0;
        @(negedge clk);
        @(negedge clk);
        check("t2_carry_step", 32'(display), 32'h0);
        @(negedge clk);
        check("t2_disp10", 32'(display), 32'h10);
        check("t2_mult",   32'(multiplier), 32'd2);
        wait_idle("t2");

        // Three lanes at multiplier 2, then a miss clears the combo.
        drive_event(8'h07, 8'h00);
        wait_idle("t3");
        check("t3_disp16", 32'(display), 32'h16);
        check("t3_combo",  32'(combo), 32'd13);
        drive_event(8'h00, 8'h20);
        check("t3_miss_combo", 32'(combo), 32'd0);
        check("t3_miss_mult",  32'(multiplier), 32'd1);

        // Back-to-back hits on different lanes accumulate while INC runs.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ponto = 8'(1 << i);
            model_event(8'(1 << i), 8'h00);
        end
        @(negedge clk);
        ponto = '0;
        wait_idle("t3_burst");
        check("t3_burst_disp", 32'(display), 32'h20);
        check("t3_burst_combo", 32'(combo), 32'd4);

        // A level held for 100 cycles counts once.
        @(negedge clk);
        ponto = 8'h10;
        model_event(8'h10, 8'h00);
        repeat (100) @(negedge clk);
        ponto = '0;
        wait_idle("t5_hold");
        check("t5_hold_disp", 32'(display), 32'h21);
        check("t5_hold_combo", 32'(combo), 32'd5);

        // Game over right after a hit: the pending point still drains.
        @(negedge clk);
        ponto = 8'h02;
        model_event(8'h02, 8'h00);
        @(negedge clk);
        ponto = '0;
        fim   = 1'b1;
        wait_idle("t5_drain");
        check("t5_drain_disp", 32'(display), 32'h22);

        // Edges while game over are ignored.
        @(negedge clk);
        ponto = 8'h04;
        erro  = 8'h01;
        model_event(8'h04, 8'h01);
        repeat (10) @(negedge clk);
        check("t5_fim_disp",  32'(display), 32'h22);
        check("t5_fim_combo", 32'(combo), 32'd6);
        check("t5_fim_busy",  32'(busy), 32'd0);
        ponto = '0;
        erro  = '0;
        @(negedge clk);
        fim = 1'b0;
        @(negedge clk);

        // Reset in the middle of a carry chain from 999.
        do_reset();
        preload(999);
        check("t6_disp999", 32'(display), 32'h999);
        @(negedge clk);
        ponto = 8'h01;
        model_event(8'h01, 8'h00);
        @(negedge clk);
        ponto = '0;
        @(negedge clk);
        @(negedge clk);
        check("t6_mid_carry", 32'(display), 32'h990);
        in_reset = 1'b1;
        sb_q.delete();
        reset = 1'b1;
        m_score = 0;
        m_combo = 0;
        #1;
        check("t6_rst_disp",  32'(display), 32'h0);
        check("t6_rst_combo", 32'(combo), 32'd0);
        check("t6_rst_mult",  32'(multiplier), 32'd1);
        check("t6_rst_busy",  32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("t6_after_disp", 32'(display), 32'h0);
        check("t6_after_busy", 32'(busy), 32'd0);
        in_reset = 1'b0;

        // Saturation at the all-nines score.
        preload(MAXSCORE - 1);
        check("t4_disp9998", 32'(display), 32'h9998);
        drive_event(8'h0F, 8'h00);
        wait_idle("t4_sat");
        check("t4_sat_disp", 32'(display), 32'h9999);
        check("t4_sat_busy", 32'(busy), 32'd0);
        drive_event(8'h01, 8'h00);
        wait_idle("t4_sat2");
        check("t4_hold_disp", 32'(display), 32'h9999);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_score_keeper
`default_nettype wire
